// File: rtl/prf_read_arbiter.sv
// prf_read_arbiter: per-bank round-robin scheduling of PRF read requesters
// onto single-port PRF banks, with a one-cycle registered data return.
module prf_read_arbiter #(
  parameter int XLEN = 32,
  parameter int PR_COUNT = 128,
  parameter int LOG_PR_COUNT = $clog2(PR_COUNT),
  parameter int PRF_BANK_COUNT = 4,
  parameter int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT),
  parameter int PRF_RR_COUNT = 11
) (
  input  logic CLK,
  input  logic RST,
  input  logic [PRF_RR_COUNT-1:0] req_valid_by_rr,
  input  logic [PRF_RR_COUNT-1:0][LOG_PR_COUNT-1:0] req_PR_by_rr,
  output logic [PRF_RR_COUNT-1:0] req_ack_by_rr,
  output logic [PRF_BANK_COUNT-1:0] bank_read_valid_by_bank,
  output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0]
    bank_read_upper_PR_by_bank,
  input  logic [PRF_BANK_COUNT-1:0][XLEN-1:0] bank_read_data_by_bank,
  output logic [PRF_RR_COUNT-1:0] rsp_valid_by_rr,
  output logic [PRF_RR_COUNT-1:0][XLEN-1:0] rsp_data_by_rr
);

  localparam int RW = $clog2(PRF_RR_COUNT);
  localparam int BW = LOG_PRF_BANK_COUNT;

  typedef logic [RW-1:0] rr_idx_t;
  typedef logic [BW-1:0] bank_t;

  logic [PRF_BANK_COUNT-1:0][RW-1:0] ptr_q;
  logic [PRF_BANK_COUNT-1:0][RW-1:0] ptr_d;
  logic [PRF_RR_COUNT-1:0][BW-1:0] bank_of;
  logic [PRF_RR_COUNT-1:0][BW-1:0] rsp_bank_q;

  always_comb begin
    for (int i = 0; i < PRF_RR_COUNT; i++) begin
      bank_of[i] = req_PR_by_rr[i][BW-1:0];
    end
  end

  // Scan each bank's candidates starting at its pointer, wrapping at the
  // last requester; the first hit wins.
  always_comb begin : arb
    logic          found;
    rr_idx_t       win;
    rr_idx_t       idx;
    logic [RW:0]   sum;
    req_ack_by_rr = '0;
    bank_read_valid_by_bank = '0;
    bank_read_upper_PR_by_bank = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    win = '0;
    idx = '0;
    sum = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      found = 1'b0;
      win = '0;
      for (int k = 0; k < PRF_RR_COUNT; k++) begin
        sum = {1'b0, ptr_q[b]} + (RW+1)'(k);
        if (sum >= (RW+1)'(PRF_RR_COUNT)) begin
          sum = sum - (RW+1)'(PRF_RR_COUNT);
        end
        idx = sum[RW-1:0];
        if (!found && req_valid_by_rr[idx] &&
            bank_of[idx] == bank_t'(b)) begin
          found = 1'b1;
          win = idx;
        end
      end
      if (found && !RST) begin
        req_ack_by_rr[win] = 1'b1;
        bank_read_valid_by_bank[b] = 1'b1;
        bank_read_upper_PR_by_bank[b] =
          req_PR_by_rr[win][LOG_PR_COUNT-1:BW];
        ptr_d[b] = (win == rr_idx_t'(PRF_RR_COUNT-1)) ?
          '0 : win + rr_idx_t'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_q <= '0;
      rsp_valid_by_rr <= '0;
      rsp_bank_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      rsp_valid_by_rr <= req_ack_by_rr;
      rsp_bank_q <= bank_of;
    end
  end

  // Zero idle lanes so unselected bank data never leaks out.
  always_comb begin
    for (int i = 0; i < PRF_RR_COUNT; i++) begin
      rsp_data_by_rr[i] = rsp_valid_by_rr[i] ?
        bank_read_data_by_bank[rsp_bank_q[i]] : '0;
    end
  end

endmodule
